// File: rtl/reg_file_wb_if.sv
// Decode/execute/writeback signal bundle for reg_file_wb.
// The master modport drives the pipeline side; the register file uses the slave modport.
interface reg_file_wb_if;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  A1D;
  logic [4:0]  A2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic        IssueLoadE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        StallD;
  logic [5:0]  PendingCnt;

  modport master (
    output RegWriteW, RdW, ResultW, A1D, A2D, IssueLoadE, RdE, FlushE,
    input  RD1D, RD2D, StallD, PendingCnt
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, A1D, A2D, IssueLoadE, RdE, FlushE,
    output RD1D, RD2D, StallD, PendingCnt
  );
endinterface

// File: rtl/reg_file_wb.sv
// 32x32 register file with a load scoreboard that stalls decode on pending loads.
// Define REGFILE_BYPASS_EN to forward the writeback value to same-cycle reads.
module reg_file_wb (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);

  logic [31:0] regs [32];
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic        wr_ok;
  logic        issue_ok;
  logic [31:0] rd1_stored;
  logic [31:0] rd2_stored;
  logic        byp1;
  logic        byp2;
  logic [5:0]  cnt;

  assign wr_ok    = bus.RegWriteW && (bus.RdW != 5'd0);
  assign issue_ok = bus.IssueLoadE && !bus.FlushE && (bus.RdE != 5'd0);

  // Clear before set so a load issuing to the register being written back wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_ok)    pending_nxt[bus.RdW] = 1'b0;
    if (issue_ok) pending_nxt[bus.RdE] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_ok) regs[bus.RdW] <= bus.ResultW;
      pending <= pending_nxt;
    end
  end

  assign rd1_stored = (bus.A1D == 5'd0) ? 32'd0 : regs[bus.A1D];
  assign rd2_stored = (bus.A2D == 5'd0) ? 32'd0 : regs[bus.A2D];

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_ok && (bus.RdW == bus.A1D);
  assign byp2 = wr_ok && (bus.RdW == bus.A2D);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign bus.RD1D = byp1 ? bus.ResultW : rd1_stored;
  assign bus.RD2D = byp2 ? bus.ResultW : rd2_stored;

  // x0 is never pending, but gate it explicitly so it can never stall.
  assign bus.StallD = ((bus.A1D != 5'd0) && pending[bus.A1D] && !byp1) ||
                      ((bus.A2D != 5'd0) && pending[bus.A2D] && !byp2);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + 6'(pending[i]);
  end

  assign bus.PendingCnt = cnt;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed vector bench for reg_file_wb; expectations adapt to REGFILE_BYPASS_EN.
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  reg_file_wb_if bus ();

  reg_file_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] res;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        issue;
    logic [4:0]  rde;
    logic        flush;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_stall;
    logic [5:0]  exp_cnt;
  } vec_t;

  vec_t vecs [20];
  int   checks;
  int   errors;

  function automatic vec_t mk(string nm, logic r, logic we, logic [4:0] rdw, logic [31:0] res,
                              logic [4:0] a1, logic [4:0] a2, logic iss, logic [4:0] rde,
                              logic fl, logic [31:0] e1, logic [31:0] e2, logic es, logic [5:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.we = we; v.rdw = rdw; v.res = res;
    v.a1 = a1; v.a2 = a2; v.issue = iss; v.rde = rde; v.flush = fl;
    v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_stall = es; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic r, input logic we, input logic [4:0] rdw, input logic [31:0] res,
                       input logic [4:0] a1, input logic [4:0] a2, input logic iss,
                       input logic [4:0] rde, input logic fl);
    rst = r;
    bus.RegWriteW = we; bus.RdW = rdw; bus.ResultW = res;
    bus.A1D = a1; bus.A2D = a2;
    bus.IssueLoadE = iss; bus.RdE = rde; bus.FlushE = fl;
  endtask

  task automatic check_outputs(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                               input logic es, input logic [5:0] ec);
    check({nm, ".rd1"},   bus.RD1D, e1);
    check({nm, ".rd2"},   bus.RD2D, e2);
    check({nm, ".stall"}, {31'd0, bus.StallD}, {31'd0, es});
    check({nm, ".cnt"},   {26'd0, bus.PendingCnt}, {26'd0, ec});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Expectations describe the combinational outputs before the vector's clock edge.
    //             name        rst we rdw   res            a1 a2  iss rde fl  rd1             rd2           stall            cnt
    vecs[0]  = mk("reset_rd",  0, 0, 0,  32'h0,          0, 5,  0, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[1]  = mk("wr_x5",     0, 1, 5,  32'hDEADBEEF,   0, 0,  0, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[2]  = mk("wr_x0",     0, 1, 0,  32'h1234,       0, 5,  0, 0, 0, 32'h0,          32'hDEADBEEF, 0,               0);
    vecs[3]  = mk("iss_x7",    0, 0, 0,  32'h0,          0, 0,  1, 7, 0, 32'h0,          32'h0,        0,               0);
    vecs[4]  = mk("stall_x7",  0, 0, 0,  32'h0,          7, 5,  0, 0, 0, 32'h0,          32'hDEADBEEF, 1,               1);
    vecs[5]  = mk("wb_x7",     0, 1, 7,  32'h55,         7, 0,  0, 0, 0, BYP ? 32'h55 : 32'h0, 32'h0,  BYP ? 1'b0 : 1'b1, 1);
    vecs[6]  = mk("after_x7",  0, 0, 0,  32'h0,          7, 0,  0, 0, 0, 32'h55,         32'h0,        0,               0);
    vecs[7]  = mk("iss_wb_x3", 0, 1, 3,  32'hAA,         0, 0,  1, 3, 0, 32'h0,          32'h0,        0,               0);
    vecs[8]  = mk("x3_pend",   0, 0, 0,  32'h0,          3, 0,  0, 0, 0, 32'hAA,         32'h0,        1,               1);
    vecs[9]  = mk("flush_x9",  0, 1, 3,  32'hBB,         0, 0,  1, 9, 1, 32'h0,          32'h0,        0,               1);
    vecs[10] = mk("iss_x0",    0, 0, 0,  32'h0,          9, 0,  1, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[11] = mk("cnt_zero",  0, 0, 0,  32'h0,          0, 0,  0, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[12] = mk("iss_x2",    0, 0, 0,  32'h0,          0, 0,  1, 2, 0, 32'h0,          32'h0,        0,               0);
    vecs[13] = mk("iss_x4",    0, 0, 0,  32'h0,          0, 0,  1, 4, 0, 32'h0,          32'h0,        0,               1);
    vecs[14] = mk("iss_x6_alu",0, 1, 12, 32'hC,          0, 0,  1, 6, 0, 32'h0,          32'h0,        0,               2);
    vecs[15] = mk("three_pend",0, 0, 0,  32'h0,          2, 6,  0, 0, 0, 32'h0,          32'h0,        1,               3);
    vecs[16] = mk("mid_rst",   1, 1, 10, 32'h77,         5, 3,  1, 8, 0, 32'hDEADBEEF,   32'hBB,       0,               3);
    vecs[17] = mk("post_rst",  0, 0, 0,  32'h0,          5, 3,  0, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[18] = mk("rst_drop",  0, 0, 0,  32'h0,          8, 10, 0, 0, 0, 32'h0,          32'h0,        0,               0);
    vecs[19] = mk("no_stall",  0, 0, 0,  32'h0,          2, 4,  0, 0, 0, 32'h0,          32'h0,        0,               0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].rdw, vecs[i].res, vecs[i].a1, vecs[i].a2,
            vecs[i].issue, vecs[i].rde, vecs[i].flush);
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_rd1, vecs[i].exp_rd2, vecs[i].exp_stall, vecs[i].exp_cnt);
    end

    // Read-port-2 path of the load/writeback handoff on x20.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 20, 0);
    #1;
    check_outputs("x20_issue", 32'h0, 32'h0, 1'b0, 6'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 20, 0, 0, 0);
    #1;
    check_outputs("x20_stall", 32'h0, 32'h0, 1'b1, 6'd1);
    @(negedge clk);
    drive(0, 1, 20, 32'h1357_9BDF, 0, 20, 0, 0, 0);
    #1;
    check_outputs("x20_wb", 32'h0, BYP ? 32'h1357_9BDF : 32'h0, BYP ? 1'b0 : 1'b1, 6'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 20, 20, 0, 0, 0);
    #1;
    check_outputs("x20_after", 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 6'd0);

    // Writeback to a non-pending register while another load is outstanding.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 31, 0);
    @(negedge clk);
    drive(0, 1, 30, 32'hFFFF_0000, 31, 0, 0, 0, 0);
    #1;
    check_outputs("alu_wb", 32'h0, 32'h0, 1'b1, 6'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 31, 30, 0, 0, 0);
    #1;
    check_outputs("alu_after", 32'h0, 32'hFFFF_0000, 1'b1, 6'd1);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
